// File: rtl/fetch_unit.sv
// Instruction-fetch stage. It issues one instruction-memory request at a
// time from the current PC and buffers the returned word in an IF/ID
// register with a valid/ready handshake. It also drives the PC register's
// load inputs: a sequential advance on each accepted fetch, or a branch
// redirect that flushes both the buffered instruction and any request
// still in flight.
module fetch_unit #(
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,          // asynchronous, active-low
  input  logic [31:0] PC,
  output logic [31:0] PCin,
  output logic        PCupdate,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  // IDLE: no request outstanding. BUSY: request outstanding, result wanted.
  // DROP: request outstanding, result to be thrown away after a redirect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;

  logic        issue;
  logic        load;

  // A fetch starts only when the IF/ID buffer will be free at the edge and
  // no redirect is pending; a wanted ack loads the buffer.
  assign issue = (state_q == IDLE) && (!valid_q || instr_ready) && !branch_taken;
  assign load  = (state_q == BUSY) && imem_ack && !branch_taken;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignment so every flop samples
      // pre-edge values regardless of process evaluation order.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaulting to the current value first keeps every path assigned,
    // so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (issue) state_d = BUSY;
      BUSY: begin
        if (imem_ack)          state_d = IDLE;
        else if (branch_taken) state_d = DROP;
      end
      DROP:    if (imem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // PC register load controls; a redirect overrides the sequential advance
  always_comb begin
    PCupdate = 1'b0;
    PCin     = PC + PC_STEP;
    if (reset) begin
      if (branch_taken) begin
        PCupdate = 1'b1;
        PCin     = branch_target;
      end else if (load) begin
        PCupdate = 1'b1;
        PCin     = addr_q + PC_STEP;
      end
    end
  end

  // Request and IF/ID next values: flush beats load, load beats consume
  always_comb begin
    req_d      = (state_d != IDLE);
    addr_d     = issue ? PC : addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (branch_taken) begin
      valid_d = 1'b0;
      instr_d = BUBBLE_INSTR;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = imem_rdata;
      instr_pc_d = addr_q;
    end else if (valid_q && instr_ready) begin
      valid_d = 1'b0;
      instr_d = BUBBLE_INSTR;
    end
  end

  // Request and IF/ID registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data registers are reset as well, because the bubble word and
      // a zero address are visible on the outputs straight out of reset.
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      instr_q    <= BUBBLE_INSTR;
      instr_pc_q <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit. A transaction-level model tracks the
// address the next fetch must use, whether a request is outstanding and
// still wanted, and whether the IF/ID buffer is occupied. Each accepted
// fetch pushes its expected (pc, word) pair into a scoreboard. A separate
// monitor pops the scoreboard whenever the decode stage takes an
// instruction. The bench also plays the PC register and the memory.
module tb_fetch_unit;

  localparam logic [31:0] STEP   = 32'd4;
  localparam logic [31:0] BUBBLE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_reg = 32'd0;
  logic [31:0] PCin;
  logic        PCupdate;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  fetch_unit #(.PC_STEP(STEP), .BUBBLE_INSTR(BUBBLE)) dut (
    .clk          (clk),
    .reset        (reset),
    .PC           (pc_reg),
    .PCin         (PCin),
    .PCupdate     (PCupdate),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready)
  );

  always #5 clk = ~clk;

  // The PC register the fetch unit closes its loop through
  always @(posedge clk) if (PCupdate) pc_reg <= PCin;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_t;

  fetch_t sb[$];
  int     n_vec  = 0;
  int     n_fail = 0;

  // Reference model state
  logic        busy      = 1'b0;   // a request is outstanding
  logic        wanted    = 1'b0;   // its result is still wanted
  logic        buf_full  = 1'b0;   // IF/ID buffer occupied
  logic [31:0] exp_pc    = 32'd0;  // address the next fetch must use
  logic [31:0] cur_addr  = 32'd0;  // address of the outstanding request
  int          wait_left = 0;

  // Stimulus knobs
  int          p_branch  = 0;
  int          p_ready   = 100;
  int          max_wait  = 0;
  logic        force_bt  = 1'b0;
  logic [31:0] force_tgt = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus model update, started just after a negedge
  task automatic cycle_body();
    logic        bt, rdy, ack, accept, issue;
    logic [31:0] tgt, e_in;
    check("imem_req", imem_req, busy);
    check("instr_valid", instr_valid, buf_full);
    if (busy) check("imem_addr", imem_addr, cur_addr);

    bt  = force_bt ? 1'b1 : ($urandom_range(0, 99) < p_branch);
    tgt = force_bt ? force_tgt : ($urandom & 32'hFFFF_FFFC);
    rdy = ($urandom_range(0, 99) < p_ready);
    ack = 1'b0;
    if (busy) begin
      if (wait_left == 0) ack = 1'b1;
      else wait_left--;
    end
    branch_taken  = bt;
    branch_target = tgt;
    instr_ready   = rdy;
    imem_ack      = ack;
    imem_rdata    = ack ? mem_word(imem_addr) : $urandom;
    #1;

    accept = busy && wanted && ack && !bt;
    issue  = !busy && (!buf_full || rdy) && !bt;
    e_in   = bt ? tgt : (accept ? cur_addr + STEP : pc_reg + STEP);
    check("PCupdate", PCupdate, bt || accept);
    check("PCin", PCin, e_in);

    if (bt) begin
      buf_full = 1'b0;
      sb.delete();
      exp_pc = tgt;
    end else if (accept) begin
      buf_full = 1'b1;
      sb.push_back('{pc: cur_addr, word: mem_word(cur_addr)});
      exp_pc = cur_addr + STEP;
    end else if (buf_full && rdy) begin
      buf_full = 1'b0;
    end

    if (busy && ack) begin
      busy = 1'b0;
    end else if (busy && bt) begin
      wanted = 1'b0;
    end else if (issue) begin
      busy      = 1'b1;
      wanted    = 1'b1;
      cur_addr  = exp_pc;
      wait_left = $urandom_range(0, max_wait);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cycle_body();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until a wanted request still has at least two wait states left
  task automatic wait_busy();
    int n = 0;
    while (!(busy && wanted && wait_left >= 2) && n < 200) begin
      step();
      n++;
    end
    check("wait_busy_budget", (n < 200), 1'b1);
  endtask

  task automatic model_reset();
    busy     = 1'b0;
    wanted   = 1'b0;
    buf_full = 1'b0;
    sb.delete();
  endtask

  // Monitor: compares each instruction the decode stage takes
  initial begin
    logic        have_prev = 1'b0;
    logic [31:0] p_instr = '0, p_pc = '0;
    fetch_t      e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev) begin
          check("hold_instr", instr, p_instr);
          check("hold_instr_pc", instr_pc, p_pc);
        end
        if (!instr_valid) check("bubble_instr", instr, BUBBLE);
        if (instr_valid && instr_ready && !branch_taken) begin
          if (sb.size() == 0) begin
            check("scoreboard_level", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("deliver_instr", instr, e.word);
            check("deliver_instr_pc", instr_pc, e.pc);
          end
        end
        have_prev = instr_valid && !instr_ready && !branch_taken;
        p_instr   = instr;
        p_pc      = instr_pc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0040;
    imem_ack      = 1'b0;
    imem_rdata    = 32'd0;
    instr_ready   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, BUBBLE);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_PCupdate", PCupdate, 1'b0);
    branch_taken = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    exp_pc = pc_reg;
    cycle_body();

    // Zero-wait memory, decode always ready: straight-line fetch 0,4,8,...
    run(30);

    // Back-pressure from decode
    p_ready = 30;
    run(60);

    // Redirect while a 3-wait-state request is in flight
    p_ready  = 100;
    max_wait = 3;
    wait_busy();
    force_bt  = 1'b1;
    force_tgt = 32'h0000_0100;
    step();
    force_bt = 1'b0;
    run(20);

    // Wrap-around of the fetch address
    max_wait  = 1;
    force_bt  = 1'b1;
    force_tgt = 32'hFFFF_FFFC;
    step();
    force_bt = 1'b0;
    run(20);

    // Random mix: redirects coincident with acks and with buffered instructions
    max_wait = 0;
    p_branch = 20;
    p_ready  = 50;
    run(800);
    max_wait = 3;
    p_branch = 10;
    run(1200);

    // Asynchronous reset in the middle of a request
    p_branch = 0;
    p_ready  = 100;
    wait_busy();
    @(negedge clk);
    #2;
    reset        = 1'b0;
    branch_taken = 1'b1;
    imem_ack     = 1'b0;
    #1;
    check("async_imem_req", imem_req, 1'b0);
    check("async_instr_valid", instr_valid, 1'b0);
    check("async_PCupdate", PCupdate, 1'b0);
    model_reset();
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    check("async_imem_addr", imem_addr, 32'd0);
    check("async_instr", instr, BUBBLE);
    reset  = 1'b1;
    exp_pc = pc_reg;
    cycle_body();
    run(40);

    @(negedge clk);
    check("final_scoreboard", sb.size(), buf_full);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly downstream of the PC register and also closes its loop. It reads the current PC and fetches the instruction word over a req/ack instruction-memory handshake. It loads the word into an IF/ID output register with a valid/ready handshake, and drives the PC register's next-value and update-enable inputs: sequential advance on each accepted fetch, or a branch redirect.

Parameters:
PC_STEP, 4, byte increment added to the fetch address after each accepted fetch
BUBBLE_INSTR, 32'h00000000, value driven on instr whenever instr_valid is 0

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
PC  input  32  current PC from the PC register
PCin  output  32  next PC value to the PC register (combinational)
PCupdate  output  1  PC register load enable (combinational, single-cycle pulse)
imem_req  output  1  instruction memory request (registered)
imem_addr  output  32  fetch address, held stable while imem_req=1 (registered)
imem_rdata  input  32  instruction word, valid when imem_ack=1
imem_ack  input  1  one-cycle completion of the outstanding request
branch_taken  input  1  redirect/flush request from the execute stage
branch_target  input  32  redirect address, valid with branch_taken
instr  output  32  IF/ID instruction
instr_pc  output  32  address the instruction was fetched from
instr_valid  output  1  IF/ID register holds a live instruction
instr_ready  input  1  decode stage accepts instr this cycle

Behaviour:
- Reset (reset=0, async): state=IDLE, imem_req=0, imem_addr=0, instr_valid=0, instr=BUBBLE_INSTR, instr_pc=0. PCupdate is forced to 0 while reset=0. An outstanding request is abandoned; memory must tolerate imem_req dropping.
- FSM states and behaviour:
  - IDLE (req=0):
    - Issue condition: (!instr_valid || instr_ready) && !branch_taken.
    - When it holds: at the clock edge, imem_addr<=PC, imem_req<=1, go BUSY.
  - BUSY (req=1, addr held):
    - imem_ack && !branch_taken: at the edge, instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, req<=0, go IDLE. Same cycle, combinationally: PCupdate=1, PCin=imem_addr+PC_STEP.
    - imem_ack && branch_taken: data discarded, go IDLE.
    - branch_taken without ack: go DROP.
  - DROP (req=1, result to be discarded): on imem_ack, discard rdata, req<=0, go IDLE. branch_taken in DROP stays DROP.
- Only one request is outstanding at a time. The buffer is loaded only by an ack, so it is always free when an ack arrives.
- Redirect:
  - branch_taken in any state (not in reset): PCupdate=1 and PCin=branch_target, overriding any sequential update in the same cycle.
  - At the edge: instr_valid<=0 and instr<=BUBBLE_INSTR. This applies even if instr_ready=1 that cycle; the flushed instruction counts as not delivered.
  - No request is issued in a redirect cycle. Fetch from the new PC starts on the next IDLE cycle.
- IF/ID handshake:
  - instr_valid && instr_ready at an edge with no concurrent load: instr_valid<=0, instr<=BUBBLE_INSTR.
  - instr, instr_pc and instr_valid hold while instr_valid && !instr_ready.
- PCupdate/PCin are 0 / PC+PC_STEP in all other cycles. PCin only matters when PCupdate=1.
- Arithmetic: 32-bit unsigned, wraps mod 2^32 (32'hFFFFFFFC+4 = 0).
- Throughput: at most one instruction per 2 cycles, reached with zero-wait ack and instr_ready=1. Fetch latency from issue to instr_valid is wait-states+2 edges.
- Back-pressure: instr_valid=1 && instr_ready=0 blocks issue; PC does not change.

Test Plan:
- Reset release with PC=0, ack one cycle after each req, instr_ready=1 -> imem_addr 0,4,8,... Each ack cycle shows PCupdate=1 with PCin=addr+4. instr_valid pulses with instr=rdata and instr_pc=0,4,8.
- Back-pressure: instr_ready=0 for 5 cycles after the first load -> imem_req stays 0, PCupdate=0, instr/instr_pc stable. Ready high -> the next fetch issues one edge later.
- Redirect mid-request: 3-wait-state memory, branch_taken with target 32'h100 during BUSY -> PCupdate=1, PCin=32'h100, DROP state, the late rdata is not loaded and causes no PCupdate. The next imem_addr is 32'h100.
- Redirect coincident with ack, and with a valid buffered instruction with instr_ready=1 -> PCin=branch_target (not addr+4), instr_valid=0 the next cycle, the ack data is discarded.
- Wrap: PC=32'hFFFFFFFC fetch -> PCin=0, the next imem_addr is 0.
- Async reset asserted mid-BUSY without a clock edge -> imem_req, instr_valid and PCupdate drop to 0 immediately. After release, fetch resumes from the current PC.
